// File: rtl/playback_sequencer.sv
// Record/playback controller for the note buffer: appends notes while recording,
// then steps through the recorded entries at the step_tick rate and drives the tone generator.
module playback_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 6,
    parameter int NOTE_TICKS = 2,
    parameter int LOOP       = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_step_tick,
    input  logic              i_toggle_pb,
    input  logic              i_rec_valid,
    input  logic [DATA_W-1:0] i_rec_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_pb_mode,
    output logic              o_note_valid,
    output logic [DATA_W-1:0] o_note_out,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_full,
    output logic              o_pb_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW    = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);

    typedef enum logic [1:0] {S_REC, S_FETCH, S_LOAD, S_PLAY} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W:0]     r_rec_len;
    logic [ADDR_W-1:0]   r_rd_idx;
    logic [TW-1:0]       r_tick_cnt;
    logic [DATA_W-1:0]   r_note_out;
    logic                r_note_valid;
    logic                r_pb_done;

    logic                w_full, w_wr_en, w_last_tick, w_more;
    logic                w_advance, w_end;
    logic [ADDR_W:0]     w_len_after, w_idx_inc;

    assign w_full      = (r_rec_len == (ADDR_W+1)'(DEPTH));
    // rst wins over a same-cycle rec_valid, so no stray write escapes during reset
    assign w_wr_en     = (r_state == S_REC) && i_rec_valid && !w_full && !i_rst;
    assign w_len_after = r_rec_len + {{ADDR_W{1'b0}}, w_wr_en};
    assign w_idx_inc   = {1'b0, r_rd_idx} + (ADDR_W+1)'(1);
    assign w_more      = (w_idx_inc < r_rec_len);
    assign w_last_tick = (r_state == S_PLAY) && i_step_tick && (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            S_REC: begin
                // counting the same-cycle write lets a lone first note be played at once
                if (i_toggle_pb && (w_len_after != '0)) w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = i_toggle_pb ? S_REC : S_LOAD;
            S_LOAD:  w_state_nxt = i_toggle_pb ? S_REC : S_PLAY;
            S_PLAY: begin
                if (i_toggle_pb) begin
                    w_state_nxt = S_REC;
                end else if (w_last_tick) begin
                    if (w_more) begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_end       = 1'b1;
                        w_state_nxt = (LOOP != 0) ? S_FETCH : S_REC;
                    end
                end
            end
            default: w_state_nxt = S_REC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_REC;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rec_len    <= '0;
            r_rd_idx     <= '0;
            r_tick_cnt   <= '0;
            r_note_out   <= '0;
            r_note_valid <= 1'b0;
            r_pb_done    <= 1'b0;
        end else begin
            r_pb_done <= w_end;
            if (w_wr_en) r_rec_len <= w_len_after;
            if ((r_state == S_REC) && (w_state_nxt == S_FETCH)) begin
                r_rd_idx   <= '0;
                r_tick_cnt <= '0;
            end
            // note field 0 is a rest: the slot keeps its timing but stays silent
            if ((r_state == S_LOAD) && !i_toggle_pb) begin
                r_note_out   <= i_mem_rd_data;
                r_note_valid <= (i_mem_rd_data[2:0] != 3'd0);
            end
            if ((r_state == S_PLAY) && !i_toggle_pb && i_step_tick) begin
                if (r_tick_cnt == TICK_LAST) begin
                    r_tick_cnt <= '0;
                    r_rd_idx   <= w_advance ? (r_rd_idx + ADDR_W'(1)) : '0;
                end else begin
                    r_tick_cnt <= r_tick_cnt + TW'(1);
                end
            end
            if (((r_state != S_REC) && i_toggle_pb) || (w_end && (LOOP == 0)))
                r_note_valid <= 1'b0;
        end
    end

    assign o_mem_wr_en   = w_wr_en;
    assign o_mem_wr_addr = r_rec_len[ADDR_W-1:0];
    assign o_mem_wr_data = i_rec_data;
    assign o_mem_rd_addr = r_rd_idx;
    assign o_pb_mode     = (r_state != S_REC);
    assign o_note_valid  = r_note_valid;
    assign o_note_out    = r_note_out;
    assign o_rec_len     = r_rec_len;
    assign o_full        = w_full;
    assign o_pb_done     = r_pb_done;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: a LOOP=0 and a LOOP=1 instance share stimulus, each with
// its own buffer RAM, and are checked against an event-level model of record/playback.
module tb_playback_sequencer;

    localparam int NT = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0, tick = 1'b0, tog = 1'b0, rv = 1'b0;
    logic [5:0] rdata = '0;

    logic       wr_en [2];
    logic [7:0] wr_addr [2];
    logic [7:0] rd_addr [2];
    logic [5:0] wr_data [2];
    logic [5:0] rd_data [2];
    logic [5:0] note [2];
    logic [8:0] len [2];
    logic       pbm [2], nv [2], full [2], done [2];
    logic [5:0] ram [2][DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        playback_sequencer #(.ADDR_W(8), .DATA_W(6), .NOTE_TICKS(NT), .LOOP(g)) dut (
            .i_clk(clk), .i_rst(rst), .i_step_tick(tick), .i_toggle_pb(tog),
            .i_rec_valid(rv), .i_rec_data(rdata),
            .o_mem_wr_en(wr_en[g]), .o_mem_wr_addr(wr_addr[g]), .o_mem_wr_data(wr_data[g]),
            .o_mem_rd_addr(rd_addr[g]), .i_mem_rd_data(rd_data[g]),
            .o_pb_mode(pbm[g]), .o_note_valid(nv[g]), .o_note_out(note[g]),
            .o_rec_len(len[g]), .o_full(full[g]), .o_pb_done(done[g])
        );
        always_ff @(posedge clk) begin
            if (wr_en[g]) ram[g][wr_addr[g]] <= wr_data[g];
            rd_data[g] <= ram[g][rd_addr[g]];
        end
    end

    int total = 0, bad = 0;
    int e = 0;

    // model: playing flag, current index, tick count, edge at which the current entry is captured
    bit         m_act [2];
    int         m_k [2], m_cnt [2], m_ld [2], m_len [2];
    logic [5:0] m_mem [2][DEPTH];
    logic [5:0] m_note [2];
    bit         m_nv [2], m_done [2];
    bit         pre_wr;
    logic [7:0] pre_wa;

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at edge %0d", name, d, act, exp, e);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit g, input bit v, input logic [5:0] dat);
        bit ewr;
        rst = r; tick = t; tog = g; rv = v; rdata = dat;
        #1;
        pre_wr = wr_en[0];
        pre_wa = wr_addr[0];
        for (int d = 0; d < 2; d++) begin
            ewr = !r && !m_act[d] && v && (m_len[d] < DEPTH);
            chk("wr_en", d, int'(wr_en[d]), int'(ewr));
            if (ewr) begin
                chk("wr_addr", d, int'(wr_addr[d]), m_len[d] % DEPTH);
                chk("wr_data", d, int'(wr_data[d]), int'(dat));
            end
        end
        @(posedge clk);
        e++;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_act[d] = 0; m_len[d] = 0; m_k[d] = 0; m_cnt[d] = 0; m_ld[d] = 0;
                m_note[d] = '0; m_nv[d] = 0; m_done[d] = 0;
            end else begin
                m_done[d] = 0;
                if (!m_act[d]) begin
                    if (v && m_len[d] < DEPTH) begin
                        m_mem[d][m_len[d]] = dat;
                        m_len[d]++;
                    end
                    if (g && m_len[d] > 0) begin
                        m_act[d] = 1; m_k[d] = 0; m_cnt[d] = 0; m_ld[d] = e + 2;
                    end
                end else if (g) begin
                    m_act[d] = 0; m_nv[d] = 0;
                end else if (e == m_ld[d]) begin
                    m_note[d] = m_mem[d][m_k[d]];
                    m_nv[d] = (m_note[d] % 8) != 0;
                end else if (e > m_ld[d] && t) begin
                    m_cnt[d]++;
                    if (m_cnt[d] == NT) begin
                        m_cnt[d] = 0;
                        if (m_k[d] + 1 < m_len[d]) begin
                            m_k[d]++; m_ld[d] = e + 2;
                        end else begin
                            m_done[d] = 1;
                            if (d == 1) begin m_k[d] = 0; m_ld[d] = e + 2; end
                            else begin m_act[d] = 0; m_nv[d] = 0; end
                        end
                    end
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("pb_mode", d, int'(pbm[d]), int'(m_act[d]));
            chk("note_valid", d, int'(nv[d]), int'(m_nv[d]));
            chk("note_out", d, int'(note[d]), int'(m_note[d]));
            chk("rec_len", d, int'(len[d]), m_len[d]);
            chk("full", d, int'(full[d]), int'(m_len[d] == DEPTH));
            chk("pb_done", d, int'(done[d]), int'(m_done[d]));
            if (m_act[d]) chk("rd_addr", d, int'(rd_addr[d]), m_k[d]);
        end
    endtask

    typedef struct {
        bit r, t, g, v;
        logic [5:0] dat;
        bit ewr;
        logic [7:0] ewa;
        bit emode, env;
        logic [5:0] enote;
        int elen;
        bit edone;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int wr_cnt, ndone, n;
        bit tg;
        logic [5:0] prev;
        logic [5:0] seq [$];

        //          r t g v dat    wr wa   md nv note   len dn
        tbl[0]  = '{1,0,0,0,6'h00, 0,8'd0, 0,0,6'h00, 0, 0};
        tbl[1]  = '{0,0,0,1,6'h21, 1,8'd0, 0,0,6'h00, 1, 0};
        tbl[2]  = '{0,0,0,1,6'h22, 1,8'd1, 0,0,6'h00, 2, 0};
        tbl[3]  = '{0,0,0,1,6'h23, 1,8'd2, 0,0,6'h00, 3, 0};
        tbl[4]  = '{0,0,1,0,6'h00, 0,8'd0, 1,0,6'h00, 3, 0};
        tbl[5]  = '{0,0,0,0,6'h00, 0,8'd0, 1,0,6'h00, 3, 0};
        tbl[6]  = '{0,1,0,0,6'h00, 0,8'd0, 1,1,6'h21, 3, 0};
        tbl[7]  = '{0,1,0,1,6'h3F, 0,8'd0, 1,1,6'h21, 3, 0};
        tbl[8]  = '{0,0,0,0,6'h00, 0,8'd0, 1,1,6'h21, 3, 0};
        tbl[9]  = '{0,1,0,0,6'h00, 0,8'd0, 1,1,6'h21, 3, 0};
        tbl[10] = '{0,0,0,0,6'h00, 0,8'd0, 1,1,6'h21, 3, 0};
        tbl[11] = '{0,0,0,0,6'h00, 0,8'd0, 1,1,6'h22, 3, 0};
        tbl[12] = '{0,1,0,0,6'h00, 0,8'd0, 1,1,6'h22, 3, 0};
        tbl[13] = '{0,1,0,0,6'h00, 0,8'd0, 1,1,6'h22, 3, 0};
        tbl[14] = '{0,0,0,0,6'h00, 0,8'd0, 1,1,6'h22, 3, 0};
        tbl[15] = '{0,0,0,0,6'h00, 0,8'd0, 1,1,6'h23, 3, 0};
        tbl[16] = '{0,1,0,0,6'h00, 0,8'd0, 1,1,6'h23, 3, 0};
        tbl[17] = '{0,1,0,0,6'h00, 0,8'd0, 0,0,6'h23, 3, 1};
        tbl[18] = '{0,0,0,0,6'h00, 0,8'd0, 0,0,6'h23, 3, 0};
        tbl[19] = '{0,0,0,1,6'h24, 1,8'd3, 0,0,6'h23, 4, 0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].g, tbl[i].v, tbl[i].dat);
            chk("tbl_wr_en", i, int'(pre_wr), int'(tbl[i].ewr));
            if (tbl[i].ewr) chk("tbl_wr_addr", i, int'(pre_wa), int'(tbl[i].ewa));
            chk("tbl_pb_mode", i, int'(pbm[0]), int'(tbl[i].emode));
            chk("tbl_note_valid", i, int'(nv[0]), int'(tbl[i].env));
            chk("tbl_note_out", i, int'(note[0]), int'(tbl[i].enote));
            chk("tbl_rec_len", i, int'(len[0]), tbl[i].elen);
            chk("tbl_pb_done", i, int'(done[0]), int'(tbl[i].edone));
        end

        // toggle with nothing recorded, then toggle together with the first write
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("empty_toggle_mode", 0, int'(pbm[0]), 0);
        chk("empty_toggle_rd", 0, int'(rd_addr[0]), 0);
        step(0, 0, 0, 0, 0);
        chk("empty_toggle_mode2", 0, int'(pbm[0]), 0);
        step(0, 0, 1, 1, 6'h15);
        chk("tog_rec_wr", 0, int'(pre_wr), 1);
        chk("tog_rec_len", 0, int'(len[0]), 1);
        chk("tog_rec_mode", 0, int'(pbm[0]), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("tog_rec_note", 0, int'(note[0]), 'h15);
        chk("tog_rec_nv", 0, int'(nv[0]), 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("tog_rec_done", 0, int'(done[0]), 1);
        chk("tog_rec_end_mode", 0, int'(pbm[0]), 0);

        // rest entry keeps its slot but stays silent
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6'h20);
        step(0, 0, 0, 1, 6'h11);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rest_note", 0, int'(note[0]), 'h20);
        chk("rest_nv", 0, int'(nv[0]), 0);
        chk("rest_mode", 0, int'(pbm[0]), 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("after_rest_note", 0, int'(note[0]), 'h11);
        chk("after_rest_nv", 0, int'(nv[0]), 1);

        // abort by toggle during PLAY, then reset during PLAY
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6'h31);
        step(0, 0, 0, 1, 6'h32);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("abort_mode", 0, int'(pbm[0]), 0);
        chk("abort_nv", 0, int'(nv[0]), 0);
        chk("abort_done", 0, int'(done[0]), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("replay_nv", 0, int'(nv[0]), 1);
        step(1, 1, 1, 1, 6'h3F);
        chk("rst_play_mode", 0, int'(pbm[0]), 0);
        chk("rst_play_nv", 0, int'(nv[0]), 0);
        chk("rst_play_note", 0, int'(note[0]), 0);
        chk("rst_play_len", 0, int'(len[0]), 0);

        // LOOP=1 instance: two entries repeat, pb_done after each pass
        step(0, 0, 0, 1, 6'h09);
        step(0, 0, 0, 1, 6'h0A);
        step(0, 0, 1, 0, 0);
        ndone = 0;
        prev = note[1];
        for (int c = 0; c < 300 && ndone < 2; c++) begin
            step(0, (c % 3) == 0, 0, 0, 0);
            if (done[1]) ndone++;
            if (note[1] != prev) begin seq.push_back(note[1]); prev = note[1]; end
        end
        chk("loop_passes", 1, ndone, 2);
        chk("loop_seq_len", 1, seq.size() >= 3 ? 1 : 0, 1);
        if (seq.size() >= 3) begin
            chk("loop_seq0", 1, int'(seq[0]), 'h09);
            chk("loop_seq1", 1, int'(seq[1]), 'h0A);
            chk("loop_seq2", 1, int'(seq[2]), 'h09);
        end
        chk("loop_mode", 1, int'(pbm[1]), 1);
        step(0, 0, 1, 0, 0);
        chk("loop_abort_mode", 1, int'(pbm[1]), 0);

        // fill the buffer: 257 pulses, exactly 256 writes
        step(1, 0, 0, 0, 0);
        wr_cnt = 0;
        for (int i = 0; i < 257; i++) begin
            step(0, 0, 0, 1, 6'(i));
            if (pre_wr) wr_cnt++;
        end
        chk("fill_writes", 0, wr_cnt, 256);
        chk("fill_last_wr", 0, int'(pre_wr), 0);
        chk("fill_len", 0, int'(len[0]), 256);
        chk("fill_full", 0, int'(full[0]), 1);

        // randomized record/playback rounds
        for (int rnd = 0; rnd < 8; rnd++) begin
            step(1, 0, 0, 0, 0);
            n = $urandom_range(1, 12);
            tg = 0;
            for (int i = 0; i < n; i++) begin
                for (int j = $urandom_range(0, 2); j > 0; j--)
                    step(0, $urandom_range(0, 1), 0, 0, 0);
                tg = (i == n - 1) && ($urandom_range(0, 1) == 1);
                step(0, $urandom_range(0, 1), tg, 1, 6'($urandom_range(0, 63)));
            end
            if (!tg) step(0, 0, 1, 0, 0);
            for (int c = 0; c < 1500 && m_act[0]; c++)
                step(0, $urandom_range(0, 3) == 0, (rnd == 7 && c == 25),
                     $urandom_range(0, 7) == 0, 6'($urandom_range(0, 63)));
            chk("rand_pass_end", rnd, int'(m_act[0]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
